// File: rtl/sfm_cast_in_unpack_if.sv
// Valid/ready stream bundle carrying data plus a byte strobe.
// Shared by the integer unpacker and its neighbouring stages.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (
    output valid,
    output data,
    output strb,
    input  ready
  );

  modport sink (
    input  valid,
    input  data,
    input  strb,
    output ready
  );

endinterface

// File: rtl/sfm_cast_in_unpack.sv
// Splits each packed integer beat into RATIO right-aligned chunks for the int-to-FP cast stage.
// Trailing chunks with an all-zero strobe are skipped; enable_i == 0 turns the block into a wire.
module sfm_cast_in_unpack #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned FPFORMAT   = 2,
  parameter int unsigned INT_WIDTH  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   enable_i,
  hwpe_stream_intf_stream.sink   stream_i,
  hwpe_stream_intf_stream.source stream_o
);

  // Format encoding follows fpnew: FP32, FP64, FP16, FP8, FP16ALT, FP8ALT.
  function automatic int unsigned fp_width(input int unsigned fmt);
    case (fmt)
      0:       return 32;
      1:       return 64;
      2:       return 16;
      3:       return 8;
      4:       return 16;
      5:       return 8;
      default: return 32;
    endcase
  endfunction

  localparam int unsigned FP_WIDTH   = fp_width(FPFORMAT);
  localparam int unsigned RATIO      = (INT_WIDTH < FP_WIDTH) ? FP_WIDTH / INT_WIDTH : 1;
  localparam int unsigned CHUNK      = DATA_WIDTH / RATIO;
  localparam int unsigned CHUNK_STRB = CHUNK / 8;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_WIDTH  = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [DATA_WIDTH-1:0] buf_data;
  logic [STRB_WIDTH-1:0] buf_strb;
  logic                  busy;
  logic [IDX_WIDTH-1:0]  idx;
  logic [IDX_WIDTH-1:0]  last_idx;
  logic                  on_last;
  logic                  in_hs;
  logic                  out_hs;

  always_comb begin
    last_idx = '0;
    for (int r = 0; r < int'(RATIO); r++) begin
      if (|buf_strb[r*CHUNK_STRB +: CHUNK_STRB]) begin
        last_idx = IDX_WIDTH'(r);
      end
    end
  end

  assign on_last = (idx == last_idx);
  assign out_hs  = busy & stream_o.ready;
  assign in_hs   = enable_i & stream_i.valid & stream_i.ready;

  // Bypass only takes over once the buffer is empty, so a beat caught by a
  // falling enable_i is still drained chunk by chunk with the input held off.
  always_comb begin
    stream_o.valid = busy;
    stream_o.data  = '0;
    stream_o.strb  = '0;
    stream_o.data[CHUNK-1:0]      = buf_data[idx*CHUNK +: CHUNK];
    stream_o.strb[CHUNK_STRB-1:0] = buf_strb[idx*CHUNK_STRB +: CHUNK_STRB];
    if (enable_i) begin
      stream_i.ready = ~clear_i & (~busy | (stream_o.ready & on_last));
    end else if (busy) begin
      stream_i.ready = 1'b0;
    end else begin
      stream_i.ready = stream_o.ready;
      stream_o.valid = stream_i.valid;
      stream_o.data  = stream_i.data;
      stream_o.strb  = stream_i.strb;
    end
  end

  // A new beat loaded on the last chunk's handshake overrides the release of busy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      buf_data <= '0;
      buf_strb <= '0;
      busy     <= 1'b0;
      idx      <= '0;
    end else begin
      if (out_hs) begin
        if (on_last) begin
          busy <= 1'b0;
          idx  <= '0;
        end else begin
          idx  <= idx + IDX_WIDTH'(1);
        end
      end
      if (in_hs) begin
        buf_data <= stream_i.data;
        buf_strb <= stream_i.strb;
        busy     <= 1'b1;
        idx      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sfm_cast_in_unpack.sv
// Scoreboard bench for sfm_cast_in_unpack with 128-bit beats, 8-bit ints and FP16 (two 64-bit chunks).
module tb_sfm_cast_in_unpack;

  localparam int DW = 128;
  localparam int SW = 16;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic clear   = 1'b0;
  logic enable  = 1'b1;

  logic ready_level = 1'b1;
  logic random_ready = 1'b0;
  logic rnd_bit = 1'b1;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  logic [DW+SW-1:0] exp_q[$];
  int out_cyc[$];

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) in_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) out_if ();

  sfm_cast_in_unpack #(
    .DATA_WIDTH(DW),
    .FPFORMAT  (2),
    .INT_WIDTH (8)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (clear),
    .enable_i(enable),
    .stream_i(in_if),
    .stream_o(out_if)
  );

  always #5 clk = ~clk;

  assign out_if.ready = random_ready ? rnd_bit : ready_level;

  always begin
    @(posedge clk);
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  task automatic checkOutput(input string name, input logic [DW+SW-1:0] act, input logic [DW+SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expectOut(input logic [DW-1:0] d, input logic [SW-1:0] s);
    exp_q.push_back({d, s});
  endtask

  // Drives one beat from posedge+1 and holds it until the DUT accepts it.
  task automatic applyStimulus(input logic [DW-1:0] d, input logic [SW-1:0] s, output time hs_time);
    int waits = 0;
    in_if.valid = 1'b1;
    in_if.data  = d;
    in_if.strb  = s;
    @(negedge clk);
    while (!in_if.ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    hs_time = $time;
    checkOutput("input_handshake", in_if.ready, 1);
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks hold-while-stalled.
  logic prev_stall = 1'b0;
  logic prev_kill  = 1'b1;
  logic [DW+SW-1:0] prev_out = '0;

  always @(negedge clk) begin : monitor
    logic [DW+SW-1:0] cur;
    logic [DW+SW-1:0] exp_v;
    cycle++;
    cur = {out_if.data, out_if.strb};
    if (prev_stall && !prev_kill) begin
      checkOutput("stall_valid", out_if.valid, 1);
      checkOutput("stall_hold", cur, prev_out);
    end
    if (out_if.valid === 1'b1 && out_if.ready === 1'b1) begin
      out_cyc.push_back(cycle);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_out: got %h, expected no output", cur);
      end else begin
        exp_v = exp_q.pop_front();
        checkOutput("out_beat", cur, exp_v);
      end
    end
    prev_stall = (out_if.valid === 1'b1) && (out_if.ready === 1'b0);
    prev_kill  = clear || !rst_n;
    prev_out   = cur;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [63:0]   lo;
    logic [63:0]   hi;
    time h1;
    time h2;
    int  c0;

    in_if.valid = 1'b0;
    in_if.data  = '0;
    in_if.strb  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_valid", out_if.valid, 0);
    checkOutput("reset_ready", in_if.ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_valid", out_if.valid, 0);
    checkOutput("post_reset_ready", in_if.ready, 1);
    @(posedge clk);
    #1;

    // Full beat: low chunk first, input held off during chunk 0 only
    $display("[TB] full beat split");
    expectOut({64'h0, 64'h2222_2222_2222_2222}, 16'h00FF);
    expectOut({64'h0, 64'h1111_1111_1111_1111}, 16'h00FF);
    applyStimulus({64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222}, 16'hFFFF, h1);
    @(negedge clk);
    checkOutput("ready_chunk0", in_if.ready, 0);
    checkOutput("valid_chunk0", out_if.valid, 1);
    @(negedge clk);
    checkOutput("ready_chunk1", in_if.ready, 1);
    @(posedge clk);
    #1;
    waitDrain();

    // Low-half-only beat yields one chunk; next beat accepted in that same cycle
    $display("[TB] single chunk beat");
    expectOut({64'h0, 64'h0123_4567_89AB_CDEF}, 16'h00FF);
    applyStimulus({64'hDEAD_BEEF_DEAD_BEEF, 64'h0123_4567_89AB_CDEF}, 16'h00FF, h1);
    expectOut({64'h0, 64'h5555_5555_5555_5555}, 16'h00FF);
    expectOut({64'h0, 64'hAAAA_AAAA_AAAA_AAAA}, 16'h00FF);
    applyStimulus({64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555}, 16'hFFFF, h2);
    checkOutput("same_cycle_accept", h2 - h1, 10);
    waitDrain();

    // Strobe corner cases: all-zero, zero interior chunk, partial strobes
    $display("[TB] strobe corners");
    expectOut({64'h0, 64'h0000_0000_0000_0007}, 16'h0000);
    applyStimulus({64'h0000_0000_0000_0009, 64'h0000_0000_0000_0007}, 16'h0000, h1);
    expectOut({64'h0, 64'h3333_3333_3333_3333}, 16'h0000);
    expectOut({64'h0, 64'h4444_4444_4444_4444}, 16'h00FF);
    applyStimulus({64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333}, 16'hFF00, h1);
    expectOut({64'h0, 64'h0102_0304_0506_0708}, 16'h003C);
    expectOut({64'h0, 64'h1112_1314_1516_1718}, 16'h000F);
    applyStimulus({64'h1112_1314_1516_1718, 64'h0102_0304_0506_0708}, 16'h0F3C, h1);
    waitDrain();

    // Four back-to-back full beats -> eight consecutive output cycles
    $display("[TB] back-to-back burst");
    c0 = out_cyc.size();
    for (int i = 0; i < 4; i++) begin
      lo = 64'h0F0F_0000_0000_0000 | 64'(i);
      hi = 64'hF0F0_0000_0000_0000 | 64'(i);
      expectOut({64'h0, lo}, 16'h00FF);
      expectOut({64'h0, hi}, 16'h00FF);
    end
    for (int i = 0; i < 4; i++) begin
      lo = 64'h0F0F_0000_0000_0000 | 64'(i);
      hi = 64'hF0F0_0000_0000_0000 | 64'(i);
      applyStimulus({hi, lo}, 16'hFFFF, h1);
    end
    waitDrain();
    if (out_cyc.size() >= c0 + 8) begin
      checkOutput("burst_consecutive", out_cyc[c0+7] - out_cyc[c0], 7);
    end else begin
      checkOutput("burst_count", out_cyc.size() - c0, 8);
    end

    // Random backpressure
    $display("[TB] random backpressure");
    random_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      lo = d[63:0];
      hi = d[127:64];
      expectOut({64'h0, lo}, 16'h00FF);
      expectOut({64'h0, hi}, 16'h00FF);
      applyStimulus(d, 16'hFFFF, h1);
    end
    waitDrain();
    random_ready = 1'b0;

    // Clear after the first chunk drops the second
    $display("[TB] clear mid-beat");
    expectOut({64'h0, 64'h6666_6666_6666_6666}, 16'h00FF);
    applyStimulus({64'h7777_7777_7777_7777, 64'h6666_6666_6666_6666}, 16'hFFFF, h1);
    @(negedge clk);
    @(posedge clk);
    #1;
    ready_level = 1'b0;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    ready_level = 1'b1;
    @(negedge clk);
    checkOutput("valid_after_clear", out_if.valid, 0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    waitDrain();

    // Reset after the first chunk drops the second
    $display("[TB] reset mid-beat");
    expectOut({64'h0, 64'h8888_8888_8888_8888}, 16'h00FF);
    applyStimulus({64'h9999_9999_9999_9999, 64'h8888_8888_8888_8888}, 16'hFFFF, h1);
    @(negedge clk);
    @(posedge clk);
    #1;
    ready_level = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_level = 1'b1;
    @(negedge clk);
    checkOutput("valid_after_reset", out_if.valid, 0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    waitDrain();

    // Bypass: combinational pass-through, ready follows downstream
    $display("[TB] bypass");
    enable = 1'b0;
    ready_level = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom};
    s = 16'hA5C3;
    expectOut(d, s);
    in_if.valid = 1'b1;
    in_if.data  = d;
    in_if.strb  = s;
    @(negedge clk);
    checkOutput("bypass_ready_low", in_if.ready, 0);
    checkOutput("bypass_valid", out_if.valid, 1);
    checkOutput("bypass_comb", {out_if.data, out_if.strb}, {d, s});
    @(posedge clk);
    #1;
    ready_level = 1'b1;
    applyStimulus(d, s, h1);
    for (int i = 1; i < 10; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      s = (i == 4) ? 16'h0000 : 16'($urandom);
      expectOut(d, s);
      applyStimulus(d, s, h1);
    end
    waitDrain();
    enable = 1'b1;
    @(negedge clk);
    checkOutput("unpack_idle_ready", in_if.ready, 1);
    checkOutput("unpack_idle_valid", out_if.valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sfm_cast_in_unpack.md
SFM_CAST_IN_UNPACK -- requirements
Module: sfm_cast_in_unpack

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default DATA_W: stream data width in bits.
REQ-002 SHALL have parameter FPFORMAT, default FPFORMAT_IN: FP format produced downstream; FP_WIDTH = fpnew_pkg::fp_width(FPFORMAT).
REQ-003 SHALL have parameter INT_WIDTH, default INT_W: integer element width in bits.
REQ-004 SHALL derive RATIO = FP_WIDTH/INT_WIDTH when INT_WIDTH < FP_WIDTH, else 1, and CHUNK = DATA_WIDTH/RATIO bits, with CHUNK/8 strobe bits per chunk.
REQ-005 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port clear_i, input, 1: synchronous soft clear.
REQ-008 SHALL have port enable_i, input, 1: 1 = unpack, 0 = bypass; changes only while the block is idle.
REQ-009 SHALL have port stream_i, hwpe_stream_intf_stream.sink, DATA_WIDTH: packed integer beats.
REQ-010 SHALL have port stream_o, hwpe_stream_intf_stream.source, DATA_WIDTH: one chunk per beat, right-aligned, for the int-to-FP cast stage.

Function
REQ-011 SHALL hold one input beat (data, strb) in a buffer register with a busy flag and a chunk index idx of width max(1,$clog2(RATIO)).
REQ-012 SHALL capture stream_i.data/strb, set busy and set idx=0 on an input handshake (stream_i.valid & stream_i.ready).
REQ-013 SHALL drive stream_o.valid = busy, with no combinational path from stream_i.valid to stream_o.valid in unpack mode.
REQ-014 SHALL drive stream_o.data = {zeros, buf_data[idx*CHUNK +: CHUNK]} and stream_o.strb = {zeros, buf_strb[idx*CHUNK/8 +: CHUNK/8]}.
REQ-015 SHALL define last_idx as the highest chunk index with a nonzero strobe slice, or 0 if the whole strobe is zero.
REQ-016 SHALL skip chunks above last_idx, so chunks 0..last_idx are emitted in ascending order and trailing all-zero-strobe chunks are never output.
REQ-017 SHALL emit interior chunks whose strobe slice is zero, with zero strb.
REQ-018 SHALL increment idx on an output handshake when idx < last_idx.
REQ-019 SHALL, on an output handshake with idx == last_idx, clear busy and reset idx to 0 in the same cycle, unless a new input handshake occurs then, in which case it loads the new beat.
REQ-020 SHALL drive stream_i.ready = ~busy | (stream_o.ready & idx == last_idx), allowing back-to-back beats with no bubble.
REQ-021 SHALL produce the first chunk one cycle after the input handshake and sustain one chunk per cycle under constant stream_o.ready.
REQ-022 SHALL hold stream_o.data/strb/valid stable while stream_o.valid & ~stream_o.ready.
REQ-023 SHALL, when RATIO == 1, act as a one-entry register slice with one output beat per input beat.
REQ-024 SHALL, in bypass mode (enable_i == 0) with busy == 0, pass stream_o = stream_i combinationally for valid, data and strb, and stream_i.ready = stream_o.ready.
REQ-025 SHALL, if enable_i falls while busy, drain the buffered beat first, holding stream_i.ready = 0 until busy clears.
REQ-026 SHALL have clear_i take precedence over both handshakes: busy = 0, idx = 0, buffer zeroed, and no input accepted in that cycle.

Reset
REQ-027 SHALL, while rst_ni == 0 at a clock edge, set busy = 0, idx = 0, and buffer data/strb = 0.
REQ-028 SHALL drive stream_o.valid = 0 out of reset, and stream_i.ready = 1 in unpack mode.
REQ-029 SHALL abandon a beat in progress when reset is asserted mid-beat, with no partial chunks emitted afterwards.

Verification (DATA_WIDTH=128, INT_WIDTH=8, FP16: RATIO=2, CHUNK=64)
REQ-030 SHALL cover: data=0x1111..._2222...(hi_lo), strb=0xFFFF, ready=1 -> out beat 1 data=0x2222... strb=0x00FF, beat 2 data=0x1111... strb=0x00FF, ready_i low only during the first chunk.
REQ-031 SHALL cover: strb=0x00FF -> exactly one output beat (low chunk), and the next input is accepted in the same cycle.
REQ-032 SHALL cover: 4 back-to-back full beats with ready always 1 -> 8 output beats in 8 consecutive cycles.
REQ-033 SHALL cover: stream_o.ready toggling randomly -> data/strb stable while stalled and output order 0,1 per beat preserved.
REQ-034 SHALL cover: clear_i or rst_ni=0 asserted after the first chunk -> second chunk never emitted, valid=0 on the next cycle.
REQ-035 SHALL cover: enable_i=0 -> output equals input in the same cycle for 10 random beats, including strb=0x0000.
